scanchain_multilane: RTL
========================

Name: scanchain_multilane

Overview:
Next-generation scan-chain cell for the tile chain. The chain width is parametrised into LANES parallel shift lanes, so a frame of NUM_IOS bits moves in NUM_IOS/LANES clocks. It adds an explicit shift enable, a synchronous reset, frame counting and a strict-latch guard. module_data_in becomes a clocked register instead of a transparent latch. The block sits between the chain controller and one user module, and passes the control signals on to the next cell.

Parameters:
NUM_IOS, 8, user IO count per direction; must be a multiple of LANES
LANES, 1, parallel scan lanes; DEPTH = NUM_IOS/LANES flops per lane
NEGEDGE_OUT, 1, 1 = data_out retimed on falling clk_in edge; 0 = direct from lane tail
STRICT_LATCH, 1, 1 = latch accepted only after exactly DEPTH shifts since last capture

Ports:
clk_in  input  1  single clock; also forwarded
reset_in  input  1  synchronous, active-high reset
data_in  input  LANES  serial input, one bit per lane
scan_select_in  input  1  capture module_data_out into chain
shift_enable_in  input  1  shift chain one position this cycle
latch_enable_in  input  1  transfer chain to module_data_in
clk_out  output  1  = clk_in
data_out  output  LANES  lane tail bits to next cell
scan_select_out  output  1  = scan_select_in
shift_enable_out  output  1  = shift_enable_in
latch_enable_out  output  1  = latch_enable_in
module_data_out  input  NUM_IOS  outputs of user module (captured)
module_data_in  output  NUM_IOS  registered inputs to user module
frame_done  output  1  one-cycle pulse when shift count reaches DEPTH
latch_error  output  1  one-cycle pulse on rejected latch request

Behaviour:
- Clock and reset: clk_in is the only clock. reset_in is synchronous and active-high.
- Reset values: chain sr, module_data_in, data_out, shift_cnt, frame_done and latch_error are all 0. The NEGEDGE_OUT flop also resets synchronously, on its own edge.
- Lane mapping: lane l owns sr[l*DEPTH +: DEPTH]. sr[l*DEPTH] is fed from data_in[l]. Tail sr[l*DEPTH+DEPTH-1] drives data_out[l]. With LANES=1 the bit order is identical to the legacy cell.
- Chain priority at each posedge:
  - reset_in;
  - then scan_select_in: sr <= module_data_out, shift_cnt <= 0;
  - then shift_enable_in: every lane shifts up one, shift_cnt++ saturating at DEPTH+1;
  - else hold.
- Latch: sampled at posedge while latch_enable_in=1. It uses the pre-update sr value, so it is unaffected by a same-cycle capture.
  - STRICT_LATCH=0: module_data_in <= sr every cycle latch_enable_in is high.
  - STRICT_LATCH=1: latch is accepted only when shift_cnt == DEPTH; otherwise module_data_in holds.
- latch_error: pulses for 1 cycle on the rising edge of latch_enable_in (previous sample 0, current 1) when the latch is rejected. It never fires when STRICT_LATCH=0.
- shift_cnt: width clog2(DEPTH+2). DEPTH+1 means overrun; any further shifts stay at DEPTH+1.
- frame_done: 1-cycle pulse in the cycle after shift_cnt goes DEPTH-1 -> DEPTH. No pulse on overrun or capture.
- data_out:
  - NEGEDGE_OUT=1: registered on negedge from the lane tail, giving a half-cycle hold margin for the next cell.
  - NEGEDGE_OUT=0: combinational from the lane tail.
- Simultaneous scan_select_in and shift_enable_in: capture wins and no shift occurs.
- Reset mid-frame: the chain is cleared, module_data_in returns to 0 and any in-progress latch is cancelled. The latch edge detector resets to 0, so latch_enable_in held high through reset produces a rising-edge event on the first cycle after reset.
- Pass-through outputs are purely combinational and unaffected by reset.

Decomposition:
- Package scanchain_pkg holds:
  - the function for the count width, clog2(DEPTH+2);
  - the chain-op encoding constants (OP_HOLD, OP_CAPTURE, OP_SHIFT);
  - the DEPTH derivation helper.
- One sub-module, scan_lane (DEPTH parameter):
  - a single lane's shift register with parallel load, serial in and tail out;
  - instantiated LANES times through a generate loop.
- Counter, latch guard, flags and negedge retiming stay in the top.

Test Plan:
- Legacy equivalence (NUM_IOS=8, LANES=1, STRICT=0): capture 0xA5, shift 8 clocks feeding 0x3C MSB-first -> data_out serially emits 1,0,1,0,0,1,0,1; after latch, module_data_in=0x3C.
- Multi-lane (NUM_IOS=8, LANES=2): capture 0xF0, shift 4 clocks with data_in lanes carrying 0x6/0x9 -> frame_done pulses once on cycle 5; latch gives module_data_in=0x96.
- Strict latch short frame (STRICT=1, DEPTH=8): capture, shift 5, raise latch_enable_in -> latch_error is 1 for exactly one cycle and module_data_in is unchanged. Shift 3 more, drop then re-raise latch -> accepted, no error.
- Overrun: shift 9 after capture -> shift_cnt saturates at DEPTH+1, no second frame_done; strict latch is rejected with latch_error.
- Capture/shift/latch collision: scan_select_in and shift_enable_in both high with latch_enable_in high and a valid frame -> sr = module_data_out, module_data_in = old sr, shift_cnt = 0.
- Reset mid-operation: assert reset_in after 3 shifts and during a latch -> the next cycle shows all outputs 0 and shift_cnt 0; data_out is 0 at the following negedge.

Source files
------------

// File: rtl/scanchain_pkg.sv
// Shared types and helpers for the multilane scan-chain cell.
// Chain-op encoding plus depth and counter-width derivations.
package scanchain_pkg;

  typedef enum logic [1:0] {
    OP_HOLD    = 2'd0,
    OP_CAPTURE = 2'd1,
    OP_SHIFT   = 2'd2
  } chain_op_e;

  function automatic int depth_of(
    input int num_ios,
    input int lanes
  );
    return num_ios / lanes;
  endfunction

  // Room for 0..DEPTH plus the DEPTH+1 overrun marker.
  function automatic int cnt_width(
    input int depth
  );
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/scan_lane.sv
// One scan lane: parallel load, serial in at bit 0,
// tail out at bit DEPTH-1.
module scan_lane
  import scanchain_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  chain_op_e        op,
  input  logic [DEPTH-1:0] load,
  input  logic             sin,
  output logic [DEPTH-1:0] q,
  output logic             tail
);

  logic [DEPTH-1:0] nxt;

  generate
    if (DEPTH == 1) begin : g_one
      assign nxt = sin;
    end else begin : g_many
      assign nxt = {q[DEPTH-2:0], sin};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      unique case (op)
        OP_CAPTURE: q <= load;
        OP_SHIFT:   q <= nxt;
        default:    q <= q;
      endcase
    end
  end

  assign tail = q[DEPTH-1];

endmodule

// File: rtl/scanchain_multilane.sv
// Multilane scan-chain cell: lanes, frame counter,
// strict-latch guard and optional negedge retiming.
module scanchain_multilane
  import scanchain_pkg::*;
#(
  parameter int NUM_IOS      = 8,
  parameter int LANES        = 1,
  parameter int NEGEDGE_OUT  = 1,
  parameter int STRICT_LATCH = 1
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic [LANES-1:0]   data_in,
  input  logic               scan_select_in,
  input  logic               shift_enable_in,
  input  logic               latch_enable_in,
  output logic               clk_out,
  output logic [LANES-1:0]   data_out,
  output logic               scan_select_out,
  output logic               shift_enable_out,
  output logic               latch_enable_out,
  input  logic [NUM_IOS-1:0] module_data_out,
  output logic [NUM_IOS-1:0] module_data_in,
  output logic               frame_done,
  output logic               latch_error
);

  localparam int DEPTH = depth_of(NUM_IOS, LANES);
  localparam int CW    = cnt_width(DEPTH);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_OVR  = CW'(DEPTH + 1);

  chain_op_e          op;
  logic [NUM_IOS-1:0] sr;
  logic [LANES-1:0]   tail;
  logic [CW-1:0]      shift_cnt;
  logic               latch_q;
  logic               latch_ok;
  logic               latch_rise;

  assign clk_out          = clk_in;
  assign scan_select_out  = scan_select_in;
  assign shift_enable_out = shift_enable_in;
  assign latch_enable_out = latch_enable_in;

  // Capture outranks shift when both are requested.
  always_comb begin
    op = OP_HOLD;
    priority case (1'b1)
      scan_select_in:  op = OP_CAPTURE;
      shift_enable_in: op = OP_SHIFT;
      default:         op = OP_HOLD;
    endcase
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    scan_lane #(
      .DEPTH(DEPTH)
    ) u_lane (
      .clk (clk_in),
      .rst (reset_in),
      .op  (op),
      .load(module_data_out[l*DEPTH +: DEPTH]),
      .sin (data_in[l]),
      .q   (sr[l*DEPTH +: DEPTH]),
      .tail(tail[l])
    );
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      shift_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (op == OP_SHIFT)
                 && (shift_cnt == CNT_LAST);
      if (op == OP_CAPTURE) begin
        shift_cnt <= '0;
      end else if (op == OP_SHIFT) begin
        if (shift_cnt != CNT_OVR) begin
          shift_cnt <= shift_cnt + CW'(1);
        end
      end
    end
  end

  assign latch_ok   = (STRICT_LATCH == 0)
                   || (shift_cnt == CNT_FULL);
  assign latch_rise = latch_enable_in && !latch_q;

  // Latch reads sr before this edge's capture or shift lands.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      module_data_in <= '0;
      latch_q        <= 1'b0;
      latch_error    <= 1'b0;
    end else begin
      latch_q     <= latch_enable_in;
      latch_error <= latch_rise && !latch_ok;
      if (latch_enable_in && latch_ok) begin
        module_data_in <= sr;
      end
    end
  end

  generate
    if (NEGEDGE_OUT != 0) begin : g_neg
      logic [LANES-1:0] dout_q;
      always_ff @(negedge clk_in) begin
        if (reset_in) begin
          dout_q <= '0;
        end else begin
          dout_q <= tail;
        end
      end
      assign data_out = dout_q;
    end else begin : g_comb
      assign data_out = tail;
    end
  endgenerate

endmodule
